// File: rtl/conv_window_mac.sv
// conv_window_mac: multi-cycle KxK convolution point engine.
// Accepts one map window plus one kernel, accumulates LANES signed products
// per cycle into a full-precision accumulator, and returns one saturated
// result per window over a valid/ready handshake.
// Optional feature macro: CONV_RELU_EN (clamp negative results to zero after
// saturation; sat still reports only the saturation clamp).
module conv_window_mac #(
    parameter int DATA_W = 8,
    parameter int K      = 5,
    parameter int LANES  = 5,
    parameter int OUT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [K*K*DATA_W-1:0]      map_block,
    input  logic [K*K*DATA_W-1:0]      kernel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           value,
    output logic                       sat,
    output logic                       busy
);

    localparam int KK    = K * K;
    localparam int N     = (KK + LANES - 1) / LANES;
    localparam int PAD   = N * LANES;
    localparam int PW    = 2 * DATA_W;
    localparam int ACC_W = 2 * DATA_W + $clog2(KK);
    localparam int IDX_W = $clog2(PAD + 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [PAD*DATA_W-1:0]     map_q, map_d;
    logic [PAD*DATA_W-1:0]     kern_q, kern_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      out_valid_q, out_valid_d;
    logic [OUT_W-1:0]          value_q, value_d;
    logic                      sat_q, sat_d;

    logic signed [PW-1:0]      prod [LANES];
    logic signed [ACC_W-1:0]   lane_sum;
    logic signed [ACC_W-1:0]   acc_sum;
    logic [OUT_W-1:0]          res_value;
    logic                      res_sat;
    logic                      last_cycle;

    // The window is held in shift registers: lane gi always reads element
    // gi of the low end, and each ACC cycle shifts LANES elements out.
    // Elements beyond K*K are zero-filled at capture, so padded lanes of the
    // final partial cycle contribute nothing.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [DATA_W-1:0] a;
        logic signed [DATA_W-1:0] b;
        assign a        = map_q[gi*DATA_W +: DATA_W];
        assign b        = kern_q[gi*DATA_W +: DATA_W];
        assign prod[gi] = PW'(a) * PW'(b);
    end

    // Sum this cycle's lane products at accumulator width.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + ACC_W'(prod[i]);
        end
        acc_sum = acc_q + lane_sum;
    end

    assign last_cycle = (32'(idx_q) + 32'(LANES)) >= 32'(KK);

    // Clamp the final accumulator into OUT_W bits, then optional ReLU.
    always_comb begin
        res_sat = 1'b0;
        if (acc_sum > SAT_MAX) begin
            res_value = SAT_MAX[OUT_W-1:0];
            res_sat   = 1'b1;
        end else if (acc_sum < SAT_MIN) begin
            res_value = SAT_MIN[OUT_W-1:0];
            res_sat   = 1'b1;
        end else begin
            res_value = acc_sum[OUT_W-1:0];
        end
`ifdef CONV_RELU_EN
        if (res_value[OUT_W-1]) begin
            res_value = '0;
        end
`else
`endif
    end

    // Next-state logic for the IDLE -> ACC -> DONE -> IDLE sequence.
    always_comb begin
        state_d     = state_q;
        map_d       = map_q;
        kern_d      = kern_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        value_d     = value_q;
        sat_d       = sat_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    map_d                    = '0;
                    map_d[KK*DATA_W-1:0]     = map_block;
                    kern_d                   = '0;
                    kern_d[KK*DATA_W-1:0]    = kernel;
                    acc_d                    = '0;
                    idx_d                    = '0;
                    state_d                  = ACC;
                end
            end
            ACC: begin
                acc_d  = acc_sum;
                idx_d  = idx_q + IDX_W'(LANES);
                map_d  = map_q >> (LANES * DATA_W);
                kern_d = kern_q >> (LANES * DATA_W);
                if (last_cycle) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    value_d     = res_value;
                    sat_d       = res_sat;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // All state registers; reset drops any in-flight window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            map_q       <= '0;
            kern_q      <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            value_q     <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            map_q       <= map_d;
            kern_q      <= kern_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            value_q     <= value_d;
            sat_q       <= sat_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign value     = value_q;
    assign sat       = sat_q;

endmodule
